// File: rtl/arc4_encrypt.sv
// RC4 encryptor: init/KSA/PRGA over an external 256x8 S RAM, reading a length-prefixed
// plaintext memory and writing a length-prefixed ciphertext memory. All memories are synchronous.
module arc4_encrypt #(
   parameter int unsigned KEY_W = 24,
   parameter int unsigned AW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             rdy,
   input  logic [KEY_W-1:0] key,
   output logic [AW-1:0]    s_addr,
   input  logic [7:0]       s_rddata,
   output logic [7:0]       s_wrdata,
   output logic             s_wren,
   output logic [AW-1:0]    pt_addr,
   input  logic [7:0]       pt_rddata,
   output logic [AW-1:0]    ct_addr,
   output logic [7:0]       ct_wrdata,
   output logic             ct_wren
);

   localparam int unsigned DW = 8;

   localparam logic [4:0] ST_IDLE  = 5'd0;
   localparam logic [4:0] ST_INIT  = 5'd1;
   localparam logic [4:0] ST_K_RDI = 5'd2;
   localparam logic [4:0] ST_K_W1  = 5'd3;
   localparam logic [4:0] ST_K_RDJ = 5'd4;
   localparam logic [4:0] ST_K_W2  = 5'd5;
   localparam logic [4:0] ST_K_WI  = 5'd6;
   localparam logic [4:0] ST_K_WJ  = 5'd7;
   localparam logic [4:0] ST_L_RD  = 5'd8;
   localparam logic [4:0] ST_L_W   = 5'd9;
   localparam logic [4:0] ST_L_CAP = 5'd10;
   localparam logic [4:0] ST_P_RDI = 5'd11;
   localparam logic [4:0] ST_P_W1  = 5'd12;
   localparam logic [4:0] ST_P_RDJ = 5'd13;
   localparam logic [4:0] ST_P_W2  = 5'd14;
   localparam logic [4:0] ST_P_WI  = 5'd15;
   localparam logic [4:0] ST_P_WJ  = 5'd16;
   localparam logic [4:0] ST_P_RDP = 5'd17;
   localparam logic [4:0] ST_P_W3  = 5'd18;
   localparam logic [4:0] ST_P_CT  = 5'd19;
   localparam logic [4:0] ST_DONE  = 5'd20;

   logic [4:0]       state, state_d;
   logic [AW-1:0]    i, i_d, j, j_d;
   logic [7:0]       k, k_d, len, len_d;
   logic [1:0]       km, km_d;
   logic [DW-1:0]    si, si_d, sj, sj_d, ptb, ptb_d;
   logic [KEY_W-1:0] key_r, key_d;
   logic             rdy_d, s_wren_d, ct_wren_d;
   logic [AW-1:0]    s_addr_d, pt_addr_d, ct_addr_d;
   logic [DW-1:0]    s_wrdata_d, ct_wrdata_d;

   logic [7:0]    key_byte_c;
   logic [AW-1:0] j_ksa_c, j_prga_c, pad_addr_c;

   // Key byte for position i mod 3, tracked by km instead of a divider
   always_comb begin
      key_byte_c = key_r[KEY_W-1 -: 8];
      case (km)
         2'd1:    key_byte_c = key_r[KEY_W-9 -: 8];
         2'd2:    key_byte_c = key_r[KEY_W-17 -: 8];
         default: key_byte_c = key_r[KEY_W-1 -: 8];
      endcase
   end

   assign j_ksa_c    = j + AW'(s_rddata) + AW'(key_byte_c);
   assign j_prga_c   = j + AW'(s_rddata);
   assign pad_addr_c = AW'(si + sj);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         len       <= '0;
         km        <= '0;
         si        <= '0;
         sj        <= '0;
         ptb       <= '0;
         key_r     <= '0;
         rdy       <= 1'b1;
         s_addr    <= '0;
         s_wrdata  <= '0;
         s_wren    <= 1'b0;
         pt_addr   <= '0;
         ct_addr   <= '0;
         ct_wrdata <= '0;
         ct_wren   <= 1'b0;
      end else begin
         state     <= state_d;
         i         <= i_d;
         j         <= j_d;
         k         <= k_d;
         len       <= len_d;
         km        <= km_d;
         si        <= si_d;
         sj        <= sj_d;
         ptb       <= ptb_d;
         key_r     <= key_d;
         rdy       <= rdy_d;
         s_addr    <= s_addr_d;
         s_wrdata  <= s_wrdata_d;
         s_wren    <= s_wren_d;
         pt_addr   <= pt_addr_d;
         ct_addr   <= ct_addr_d;
         ct_wrdata <= ct_wrdata_d;
         ct_wren   <= ct_wren_d;
      end
   end

   // Next state and next registered outputs; write strobes default low so each lasts one cycle
   always_comb begin
      state_d     = state;
      i_d         = i;
      j_d         = j;
      k_d         = k;
      len_d       = len;
      km_d        = km;
      si_d        = si;
      sj_d        = sj;
      ptb_d       = ptb;
      key_d       = key_r;
      rdy_d       = rdy;
      s_addr_d    = s_addr;
      s_wrdata_d  = s_wrdata;
      s_wren_d    = 1'b0;
      pt_addr_d   = pt_addr;
      ct_addr_d   = ct_addr;
      ct_wrdata_d = ct_wrdata;
      ct_wren_d   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (en) begin
               key_d   = key;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               len_d   = '0;
               km_d    = '0;
               rdy_d   = 1'b0;
               state_d = ST_INIT;
            end
         end

         ST_INIT: begin
            s_addr_d   = i;
            s_wrdata_d = DW'(i);
            s_wren_d   = 1'b1;
            i_d        = i + AW'(1);
            if (&i) begin
               j_d     = '0;
               km_d    = '0;
               state_d = ST_K_RDI;
            end
         end

         ST_K_RDI: begin
            s_addr_d = i;
            state_d  = ST_K_W1;
         end

         ST_K_W1: state_d = ST_K_RDJ;

         ST_K_RDJ: begin
            si_d     = s_rddata;
            j_d      = j_ksa_c;
            s_addr_d = j_ksa_c;
            state_d  = ST_K_W2;
         end

         ST_K_W2: state_d = ST_K_WI;

         ST_K_WI: begin
            sj_d       = s_rddata;
            s_addr_d   = i;
            s_wrdata_d = s_rddata;
            s_wren_d   = 1'b1;
            state_d    = ST_K_WJ;
         end

         // Second half of the swap; when i==j both writes carry the original S[i]
         ST_K_WJ: begin
            s_addr_d   = j;
            s_wrdata_d = si;
            s_wren_d   = 1'b1;
            i_d        = i + AW'(1);
            km_d       = (km == 2'd2) ? 2'd0 : km + 2'd1;
            state_d    = (&i) ? ST_L_RD : ST_K_RDI;
         end

         ST_L_RD: begin
            pt_addr_d = '0;
            state_d   = ST_L_W;
         end

         ST_L_W: state_d = ST_L_CAP;

         // Length byte is copied to ct[0] unencrypted
         ST_L_CAP: begin
            len_d       = pt_rddata;
            ct_addr_d   = '0;
            ct_wrdata_d = pt_rddata;
            ct_wren_d   = 1'b1;
            i_d         = '0;
            j_d         = '0;
            k_d         = 8'd1;
            state_d     = (pt_rddata == 8'd0) ? ST_DONE : ST_P_RDI;
         end

         ST_P_RDI: begin
            i_d      = i + AW'(1);
            s_addr_d = i + AW'(1);
            state_d  = ST_P_W1;
         end

         ST_P_W1: state_d = ST_P_RDJ;

         // Plaintext byte fetch overlaps the S[j] read
         ST_P_RDJ: begin
            si_d      = s_rddata;
            j_d       = j_prga_c;
            s_addr_d  = j_prga_c;
            pt_addr_d = AW'(k);
            state_d   = ST_P_W2;
         end

         ST_P_W2: state_d = ST_P_WI;

         ST_P_WI: begin
            sj_d       = s_rddata;
            ptb_d      = pt_rddata;
            s_addr_d   = i;
            s_wrdata_d = s_rddata;
            s_wren_d   = 1'b1;
            state_d    = ST_P_WJ;
         end

         ST_P_WJ: begin
            s_addr_d   = j;
            s_wrdata_d = si;
            s_wren_d   = 1'b1;
            state_d    = ST_P_RDP;
         end

         // Sum of the swapped pair is order-independent, so the pre-swap copies suffice
         ST_P_RDP: begin
            s_addr_d = pad_addr_c;
            state_d  = ST_P_W3;
         end

         ST_P_W3: state_d = ST_P_CT;

         ST_P_CT: begin
            ct_addr_d   = AW'(k);
            ct_wrdata_d = ptb ^ s_rddata;
            ct_wren_d   = 1'b1;
            k_d         = k + 8'd1;
            state_d     = (k == len) ? ST_DONE : ST_P_RDI;
         end

         ST_DONE: begin
            rdy_d   = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule
